// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: instruction field codes,
// PSR bit positions, FSM state encoding and the decoder result payload.
package alu_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_W   = 8;
  localparam int unsigned PSR_W   = 5;

  // op hi field, instr[15:12]
  localparam logic [3:0] OP_REG   = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_ADDUI = 4'b0110;
  localparam logic [3:0] OP_ADDCI = 4'b0111;
  localparam logic [3:0] OP_GRP8  = 4'b1000;

  // op ext field, instr[7:4], under OP_REG
  localparam logic [3:0] EXT_NOP   = 4'b0000;
  localparam logic [3:0] EXT_CMP   = 4'b1011;
  localparam logic [3:0] EXT_CMPU  = 4'b1111;
  localparam logic [3:0] EXT_RSV_A = 4'b1010;
  localparam logic [3:0] EXT_RSV_C = 4'b1100;
  localparam logic [3:0] EXT_RSV_D = 4'b1101;
  localparam logic [3:0] EXT_RSV_E = 4'b1110;

  // op ext field, instr[7:4], legal under OP_GRP8
  localparam logic [3:0] EXT_G8_0 = 4'b0000;
  localparam logic [3:0] EXT_G8_1 = 4'b0001;
  localparam logic [3:0] EXT_G8_4 = 4'b0100;

  // PSR bit indices {Z,C,F,N,L}
  localparam int unsigned PSR_Z = 4;
  localparam int unsigned PSR_C = 3;
  localparam int unsigned PSR_F = 2;
  localparam int unsigned PSR_N = 1;
  localparam int unsigned PSR_L = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WB    = 2'd2
  } state_e;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic             use_imm;
    logic             wb_en;
    logic             psr_en;
    logic             illegal;
  } decode_t;

  // Reserved ext codes in the register-op group
  function automatic logic reg_ext_reserved(input logic [3:0] ext);
    return (ext == EXT_RSV_A) || (ext == EXT_RSV_C) ||
           (ext == EXT_RSV_D) || (ext == EXT_RSV_E);
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational instruction decoder.
//   instr : 16-bit instruction word
//   dec_c : ALU opcode, immediate select, writeback/PSR enables, illegal flag
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output decode_t            dec_c
);

  logic [3:0] op_hi;
  logic [3:0] op_ext;

  assign op_hi  = instr[15:12];
  assign op_ext = instr[7:4];

  // Classify the op; illegal words leave every enable low
  always_comb begin
    dec_c         = '0;
    dec_c.opcode  = {op_hi, op_ext};
    case (op_hi)
      OP_REG: begin
        if (reg_ext_reserved(op_ext)) begin
          dec_c.illegal = 1'b1;
        end else if ((op_ext == EXT_CMP) || (op_ext == EXT_CMPU)) begin
          dec_c.psr_en = 1'b1;
        end else if (op_ext != EXT_NOP) begin
          dec_c.wb_en  = 1'b1;
          dec_c.psr_en = 1'b1;
        end
      end
      OP_ADDI, OP_ADDUI, OP_ADDCI: begin
        dec_c.use_imm = 1'b1;
        dec_c.wb_en   = 1'b1;
        dec_c.psr_en  = 1'b1;
      end
      OP_GRP8: begin
        if ((op_ext == EXT_G8_0) || (op_ext == EXT_G8_1) || (op_ext == EXT_G8_4)) begin
          dec_c.wb_en  = 1'b1;
          dec_c.psr_en = 1'b1;
        end else begin
          dec_c.illegal = 1'b1;
        end
      end
      default: dec_c.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for a single external ALU: accepts one instruction every
// three cycles (IDLE -> ISSUE -> WB), reads operands, drives the ALU,
// captures result/flags and writes the result back to the register file.
//   clk, reset_n            : clock, async active-low reset
//   instr_valid/instr/ready : instruction handshake (ready only in IDLE)
//   rf_ra_*/rf_rb_*         : Rdest/Rsrc read ports (combinational data)
//   rf_we/rf_waddr/rf_wdata : writeback port, one-cycle strobe in WB
//   alu_a/b/opcode/cin      : ALU drive, zero outside ISSUE
//   alu_c/alu_flags         : ALU result and {Z,C,F,N,L}
//   psr                     : registered flags
//   illegal                 : one-cycle pulse in ISSUE for undecodable words
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic [REG_AW-1:0]  rf_ra_addr,
  output logic [REG_AW-1:0]  rf_rb_addr,
  input  logic [DATA_W-1:0]  rf_ra_data,
  input  logic [DATA_W-1:0]  rf_rb_data,
  output logic               rf_we,
  output logic [REG_AW-1:0]  rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [OPC_W-1:0]   alu_opcode,
  output logic               alu_cin,
  input  logic [DATA_W-1:0]  alu_c,
  input  logic [PSR_W-1:0]   alu_flags,
  output logic [PSR_W-1:0]   psr,
  output logic               illegal
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PSR_W-1:0]   psr_q, psr_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               we_q, we_d;
  logic               illegal_q, illegal_d;
  logic [INSTR_W-1:0] dec_in;
  decode_t            dec;

  // In IDLE decode the offered word so illegal can be registered into ISSUE;
  // otherwise decode the latched word.
  assign dec_in = (state_q == ST_IDLE) ? instr : instr_q;

  alu_issue_decode u_decode (
    .instr (dec_in),
    .dec_c (dec)
  );

  // Gated by reset so the handshake is closed while reset is held
  assign instr_ready = reset_n && (state_q == ST_IDLE);

  assign rf_ra_addr = REG_AW'(instr_q[11:8]);
  assign rf_rb_addr = REG_AW'(instr_q[3:0]);
  assign rf_waddr   = REG_AW'(instr_q[11:8]);
  assign rf_wdata   = result_q;
  assign rf_we      = we_q;
  assign psr        = psr_q;
  assign illegal    = illegal_q;

  // ALU drive, only meaningful for a legal instruction in ISSUE
  always_comb begin
    alu_a      = '0;
    alu_b      = '0;
    alu_opcode = '0;
    alu_cin    = 1'b0;
    if ((state_q == ST_ISSUE) && !dec.illegal) begin
      alu_opcode = dec.opcode;
      alu_a      = rf_ra_data;
      alu_b      = dec.use_imm ? DATA_W'(instr_q[7:0]) : rf_rb_data;
      alu_cin    = psr_q[PSR_C];
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    psr_d     = psr_q;
    result_d  = result_q;
    we_d      = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid && instr_ready) begin
          instr_d   = instr;
          illegal_d = dec.illegal;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!dec.illegal) begin
          if (dec.psr_en) psr_d = alu_flags;
          if (dec.wb_en) begin
            result_d = alu_c;
            we_d     = 1'b1;
          end
        end
        state_d = ST_WB;
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      psr_q     <= '0;
      result_q  <= '0;
      we_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      psr_q     <= psr_d;
      result_q  <= result_d;
      we_q      <= we_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a register-file model, an ALU model
// and a writeback scoreboard.
module tb_alu_issue_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;

  logic          clk;
  logic          reset_n;
  logic          instr_valid;
  logic [15:0]   instr;
  logic          instr_ready;
  logic [AW-1:0] rf_ra_addr, rf_rb_addr, rf_waddr;
  logic [DW-1:0] rf_ra_data, rf_rb_data, rf_wdata;
  logic          rf_we;
  logic [DW-1:0] alu_a, alu_b, alu_c;
  logic [7:0]    alu_opcode;
  logic          alu_cin;
  logic [4:0]    alu_flags, psr;
  logic          illegal;

  alu_issue_ctrl #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .rf_ra_addr  (rf_ra_addr),
    .rf_rb_addr  (rf_rb_addr),
    .rf_ra_data  (rf_ra_data),
    .rf_rb_data  (rf_rb_data),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_opcode  (alu_opcode),
    .alu_cin     (alu_cin),
    .alu_c       (alu_c),
    .alu_flags   (alu_flags),
    .psr         (psr),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model
  logic [DW-1:0] regs [16];
  assign rf_ra_data = regs[rf_ra_addr];
  assign rf_rb_data = regs[rf_rb_addr];

  // ALU model: add family, compares, everything else as XOR
  logic [3:0]  m_hi, m_ext;
  logic        m_cin;
  logic [16:0] m_sum;
  always_comb begin
    m_hi      = alu_opcode[7:4];
    m_ext     = alu_opcode[3:0];
    m_cin     = 1'b0;
    m_sum     = '0;
    alu_c     = '0;
    alu_flags = '0;
    if ((m_hi == 4'h0 && (m_ext == 4'h5 || m_ext == 4'h6 || m_ext == 4'h7)) ||
        m_hi == 4'h5 || m_hi == 4'h6 || m_hi == 4'h7) begin
      m_cin        = ((m_hi == 4'h0 && m_ext == 4'h7) || m_hi == 4'h7) ? alu_cin : 1'b0;
      m_sum        = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0, m_cin};
      alu_c        = m_sum[15:0];
      alu_flags[4] = (m_sum[15:0] == 16'h0);
      alu_flags[3] = m_sum[16];
      alu_flags[2] = (alu_a[15] == alu_b[15]) && (m_sum[15] != alu_a[15]);
    end else if (m_hi == 4'h0 && (m_ext == 4'hB || m_ext == 4'hF)) begin
      alu_flags[4] = (alu_a == alu_b);
      alu_flags[1] = ($signed(alu_a) < $signed(alu_b));
      alu_flags[0] = (alu_a < alu_b);
    end else begin
      alu_c        = alu_a ^ alu_b;
      alu_flags[4] = ((alu_a ^ alu_b) == 16'h0);
    end
  end

  typedef struct packed {
    logic [3:0]  waddr;
    logic [15:0] wdata;
  } wb_t;
  wb_t sb[$];

  int         n_chk;
  int         n_fail;
  logic [4:0] cur_psr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one instruction and follow it through ISSUE and WB
  task automatic send(input logic [15:0] ins, input logic exp_we, input logic [3:0] exp_waddr,
                      input logic [15:0] exp_wdata, input logic exp_ill, input logic [4:0] exp_psr);
    wb_t         e;
    wb_t         got;
    logic [7:0]  exp_opc;
    logic [15:0] exp_b;
    logic        is_imm;
    exp_opc = {ins[15:12], ins[7:4]};
    is_imm  = (ins[15:12] == 4'h5) || (ins[15:12] == 4'h6) || (ins[15:12] == 4'h7);
    exp_b   = is_imm ? {8'h00, ins[7:0]} : regs[ins[3:0]];

    @(negedge clk);
    check("ready_idle", 32'(instr_ready), 32'd1);
    instr       = ins;
    instr_valid = 1'b1;
    if (exp_we) begin
      e.waddr = exp_waddr;
      e.wdata = exp_wdata;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 16'h0000;

    @(negedge clk);  // ISSUE
    check("ready_issue", 32'(instr_ready), 32'd0);
    check("illegal_issue", 32'(illegal), 32'(exp_ill));
    check("we_issue", 32'(rf_we), 32'd0);
    if (!exp_ill) begin
      check("alu_opcode", 32'(alu_opcode), 32'(exp_opc));
      check("alu_a", 32'(alu_a), 32'(regs[ins[11:8]]));
      check("alu_b", 32'(alu_b), 32'(exp_b));
      check("alu_cin", 32'(alu_cin), 32'(cur_psr[3]));
    end

    @(negedge clk);  // WB
    check("rf_we", 32'(rf_we), 32'(exp_we));
    check("illegal_wb", 32'(illegal), 32'd0);
    check("psr", 32'(psr), 32'(exp_psr));
    check("alu_idle", 32'(alu_opcode), 32'd0);
    if (rf_we) begin
      if (sb.size() != 0) begin
        got = sb.pop_front();
        check("rf_waddr", 32'(rf_waddr), 32'(got.waddr));
        check("rf_wdata", 32'(rf_wdata), 32'(got.wdata));
      end
      regs[rf_waddr] = rf_wdata;
    end else if (sb.size() != 0) begin
      void'(sb.pop_front());
    end
    cur_psr = exp_psr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    cur_psr     = 5'b00000;
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    for (int i = 0; i < 16; i++) regs[i] = 16'h0000;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(instr_ready), 32'd0);
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_psr", 32'(psr), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_wdata", 32'(rf_wdata), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(instr_ready), 32'd1);

    // ADD R1,R2
    regs[1] = 16'h0003;
    regs[2] = 16'h0004;
    send(16'h0152, 1'b1, 4'd1, 16'h0007, 1'b0, 5'b00000);
    // Dependent ADDI R1,0x10 issued back to back
    send(16'h5110, 1'b1, 4'd1, 16'h0017, 1'b0, 5'b00000);
    // ADDUI R3,1 wraps to zero
    regs[3] = 16'hFFFF;
    send(16'h6301, 1'b1, 4'd3, 16'h0000, 1'b0, 5'b11000);
    // ADDC with carry in
    regs[1] = 16'h0001;
    regs[2] = 16'h0001;
    send(16'h0172, 1'b1, 4'd1, 16'h0003, 1'b0, 5'b00000);
    // CMP 2 vs 5, CMPU equal
    regs[1] = 16'h0002;
    regs[2] = 16'h0005;
    send(16'h01B2, 1'b0, 4'd0, 16'h0000, 1'b0, 5'b00011);
    regs[4] = 16'h0009;
    regs[5] = 16'h0009;
    send(16'h04F5, 1'b0, 4'd0, 16'h0000, 1'b0, 5'b10000);
    // NOP leaves psr alone
    send(16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 5'b10000);
    // Illegal words: bad op hi, reserved reg ext, bad group-8 ext
    send(16'h3000, 1'b0, 4'd0, 16'h0000, 1'b1, 5'b10000);
    send(16'h01A2, 1'b0, 4'd0, 16'h0000, 1'b1, 5'b10000);
    send(16'h8120, 1'b0, 4'd0, 16'h0000, 1'b1, 5'b10000);
    // Group-8 op
    regs[6] = 16'h00F0;
    regs[7] = 16'h0F0F;
    send(16'h8607, 1'b1, 4'd6, 16'h0FFF, 1'b0, 5'b00000);
    // ADDCI with carry clear
    regs[8] = 16'h0005;
    send(16'h7812, 1'b1, 4'd8, 16'h0017, 1'b0, 5'b00000);

    // Reset asserted during WB aborts the writeback
    regs[3] = 16'hFFFF;
    @(negedge clk);
    check("ready_pre_abort", 32'(instr_ready), 32'd1);
    instr       = 16'h6301;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    check("we_before_rst", 32'(rf_we), 32'd1);
    check("psr_before_rst", 32'(psr), 32'h18);
    reset_n = 1'b0;
    #1;
    check("abort_we", 32'(rf_we), 32'd0);
    check("abort_psr", 32'(psr), 32'd0);
    check("abort_ready", 32'(instr_ready), 32'd0);
    check("abort_waddr", 32'(rf_waddr), 32'd0);
    @(posedge clk);
    #1;
    check("abort_we_edge", 32'(rf_we), 32'd0);
    reset_n = 1'b1;
    cur_psr = 5'b00000;
    @(negedge clk);
    check("abort_ready_rel", 32'(instr_ready), 32'd1);
    check("abort_psr_rel", 32'(psr), 32'd0);

    // Normal operation resumes
    regs[1] = 16'h0003;
    regs[2] = 16'h0004;
    send(16'h0152, 1'b1, 4'd1, 16'h0007, 1'b0, 5'b00000);

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
